// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance sequencer.
//   TLB_ENTRY_W    packed entry width
//   tlb_entry_t    packed entry layout, e at the MSB
//   OP_* / INV_*   op codes and INVTLB op types
//   op_state_e     sequencer states
//   va_match()     page-size aware VPPN compare
package tlb_pkg;

    localparam int TLB_ENTRY_W = 89;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    localparam logic [4:0] INV_ALL0    = 5'd0;
    localparam logic [4:0] INV_ALL1    = 5'd1;
    localparam logic [4:0] INV_GLB     = 5'd2;
    localparam logic [4:0] INV_NGLB    = 5'd3;
    localparam logic [4:0] INV_ASID    = 5'd4;
    localparam logic [4:0] INV_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GA_VA   = 5'd6;

    localparam logic [5:0] PS_4K  = 6'd12;
    localparam logic [5:0] PS_4M  = 6'd22;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRCH,
        ST_RD,
        ST_WR,
        ST_INV_RD,
        ST_INV_WR,
        ST_RESP
    } op_state_e;

    // 4M pages ignore the low 10 VPPN bits.
    function automatic logic va_match(input logic [18:0] a, input logic [18:0] b,
                                      input logic [5:0] ps);
        if (ps == PS_4M) return a[18:10] == b[18:10];
        return a == b;
    endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// INVTLB selection rule for one entry. Purely combinational; the entry's
// valid bit is checked by the caller.
//   e_vppn/e_ps/e_asid/e_g  entry fields under test
//   inv_type                INVTLB op type (types above 6 never match)
//   inv_asid/inv_vppn       op operands
//   match                   entry is selected by this op
module tlb_inv_match
    import tlb_pkg::*;
(
    input  logic [18:0] e_vppn,
    input  logic [5:0]  e_ps,
    input  logic [9:0]  e_asid,
    input  logic        e_g,
    input  logic [4:0]  inv_type,
    input  logic [9:0]  inv_asid,
    input  logic [18:0] inv_vppn,
    output logic        match
);

    logic asid_eq;
    logic va_eq;

    assign asid_eq = (e_asid == inv_asid);
    assign va_eq   = va_match(e_vppn, inv_vppn, e_ps);

    always_comb begin
        match = 1'b0;
        case (inv_type)
            INV_ALL0, INV_ALL1: match = 1'b1;
            INV_GLB:            match = e_g;
            INV_NGLB:           match = !e_g;
            INV_ASID:           match = !e_g && asid_eq;
            INV_ASID_VA:        match = !e_g && asid_eq && va_eq;
            INV_GA_VA:          match = (e_g || asid_eq) && va_eq;
            default:            match = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer. Takes one op via valid/ready, drives the TLB
// search/read/write ports, then pulses rsp_valid for one cycle.
//   clk, resetn                      clock, async active-low reset
//   op_valid/op_ready                request handshake (ready only in IDLE)
//   op_code/op_index/op_entry        op, RD/WR index, WR/FILL entry
//   op_inv_type/op_inv_asid/_vppn    INVTLB type, SRCH/INV operands
//   rsp_valid/found/index/entry      response, held until the next response
//   s_*                              search port (s_va_bit12 tied low)
//   r_index/r_entry                  read port
//   we/w_index/w_entry               write port
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [2:0]             op_code,
    input  logic [IDXW-1:0]        op_index,
    input  logic [TLB_ENTRY_W-1:0] op_entry,
    input  logic [4:0]             op_inv_type,
    input  logic [9:0]             op_inv_asid,
    input  logic [18:0]            op_inv_vppn,
    output logic                   rsp_valid,
    output logic                   rsp_found,
    output logic [IDXW-1:0]        rsp_index,
    output logic [TLB_ENTRY_W-1:0] rsp_entry,
    output logic [18:0]            s_vppn,
    output logic [9:0]             s_asid,
    output logic                   s_va_bit12,
    input  logic                   s_found,
    input  logic [IDXW-1:0]        s_index,
    output logic [IDXW-1:0]        r_index,
    input  logic [TLB_ENTRY_W-1:0] r_entry,
    output logic                   we,
    output logic [IDXW-1:0]        w_index,
    output logic [TLB_ENTRY_W-1:0] w_entry
);

    op_state_e              state, state_d;
    logic [2:0]             op_q;
    logic [IDXW-1:0]        idx_q, fill_ptr, sweep_idx;
    logic [TLB_ENTRY_W-1:0] entry_q, inv_ent;
    logic [4:0]             inv_type_q;
    logic [9:0]             asid_q;
    logic [18:0]            vppn_q;
    logic                   inv_hit;
    tlb_entry_t             rd_ent;
    logic                   inv_match, sweep_last, illegal;

    assign rd_ent     = r_entry;
    assign sweep_last = (sweep_idx == IDXW'(TLBNUM - 1));
    assign s_va_bit12 = 1'b0;
    // Rejected ops go straight to RESP without touching the TLB.
    assign illegal    = (op_code > OP_INV) || (op_code == OP_INV && op_inv_type > INV_GA_VA);

    tlb_inv_match u_inv_match (
        .e_vppn   (rd_ent.vppn),
        .e_ps     (rd_ent.ps),
        .e_asid   (rd_ent.asid),
        .e_g      (rd_ent.g),
        .inv_type (inv_type_q),
        .inv_asid (asid_q),
        .inv_vppn (vppn_q),
        .match    (inv_match)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_d;
    end

    // Port drives are decoded from state alone so that an async reset
    // drops we in the same cycle.
    always_comb begin
        state_d   = state;
        op_ready  = 1'b0;
        rsp_valid = 1'b0;
        s_vppn    = '0;
        s_asid    = '0;
        r_index   = '0;
        we        = 1'b0;
        w_index   = '0;
        w_entry   = '0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (illegal)                state_d = ST_RESP;
                    else if (op_code == OP_SRCH) state_d = ST_SRCH;
                    else if (op_code == OP_RD)   state_d = ST_RD;
                    else if (op_code == OP_INV)  state_d = ST_INV_RD;
                    else                         state_d = ST_WR;
                end
            end
            ST_SRCH: begin
                s_vppn  = vppn_q;
                s_asid  = asid_q;
                state_d = ST_RESP;
            end
            ST_RD: begin
                r_index = idx_q;
                state_d = ST_RESP;
            end
            ST_WR: begin
                we      = 1'b1;
                w_index = (op_q == OP_FILL) ? fill_ptr : idx_q;
                w_entry = entry_q;
                state_d = ST_RESP;
            end
            ST_INV_RD: begin
                r_index = sweep_idx;
                if (inv_match && rd_ent.e) state_d = ST_INV_WR;
                else if (sweep_last)       state_d = ST_RESP;
            end
            ST_INV_WR: begin
                we      = 1'b1;
                w_index = sweep_idx;
                w_entry = {1'b0, inv_ent[TLB_ENTRY_W-2:0]};
                state_d = sweep_last ? ST_RESP : ST_INV_RD;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latches, sweep bookkeeping and response capture. rsp_* only
    // change on the edge that enters RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= '0;
            idx_q      <= '0;
            entry_q    <= '0;
            inv_type_q <= '0;
            asid_q     <= '0;
            vppn_q     <= '0;
            fill_ptr   <= '0;
            sweep_idx  <= '0;
            inv_ent    <= '0;
            inv_hit    <= 1'b0;
            rsp_found  <= 1'b0;
            rsp_index  <= '0;
            rsp_entry  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (op_valid) begin
                    op_q       <= op_code;
                    idx_q      <= op_index;
                    entry_q    <= op_entry;
                    inv_type_q <= op_inv_type;
                    asid_q     <= op_inv_asid;
                    vppn_q     <= op_inv_vppn;
                    sweep_idx  <= '0;
                    inv_hit    <= 1'b0;
                    if (illegal) begin
                        rsp_found <= 1'b0;
                        rsp_index <= '0;
                        rsp_entry <= '0;
                    end
                end
                ST_SRCH: begin
                    rsp_found <= s_found;
                    rsp_index <= s_found ? s_index : '0;
                    rsp_entry <= '0;
                end
                ST_RD: begin
                    rsp_found <= 1'b0;
                    rsp_index <= '0;
                    rsp_entry <= rd_ent.e ? r_entry : '0;
                end
                ST_WR: begin
                    rsp_found <= 1'b0;
                    rsp_index <= w_index;
                    rsp_entry <= '0;
                    if (op_q == OP_FILL) fill_ptr <= fill_ptr + IDXW'(1);
                end
                ST_INV_RD: begin
                    if (inv_match && rd_ent.e) begin
                        inv_ent <= r_entry;
                    end else begin
                        sweep_idx <= sweep_idx + IDXW'(1);
                        if (sweep_last) begin
                            rsp_found <= inv_hit;
                            rsp_index <= '0;
                            rsp_entry <= '0;
                        end
                    end
                end
                ST_INV_WR: begin
                    inv_hit   <= 1'b1;
                    sweep_idx <= sweep_idx + IDXW'(1);
                    if (sweep_last) begin
                        rsp_found <= 1'b1;
                        rsp_index <= '0;
                        rsp_entry <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
